// File: rtl/sw_debounce.sv
// Two-bank DIP-switch synchroniser and debouncer feeding the display multiplexer.
// Each bank is accepted only after its synchronised value has held for STABLE_CYCLES clocks.
`timescale 1ns/1ps
module sw_debounce #(
  parameter int WIDTH         = 4,
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 60000,
  parameter bit ACTIVE_LOW    = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] onboard_sw_raw,
  input  logic [WIDTH-1:0] bboard_sw_raw,
  output logic [WIDTH-1:0] onboard_sw,
  output logic [WIDTH-1:0] bboard_sw,
  output logic             sw_changed
);

  localparam int CNT_W = $clog2(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [WIDTH-1:0] RAW_IDLE = {WIDTH{ACTIVE_LOW}};

  logic [WIDTH-1:0] raw [2];
  logic [WIDTH-1:0] deb [2];
  logic             bank_upd [2];

  assign raw[0] = onboard_sw_raw;
  assign raw[1] = bboard_sw_raw;

  for (genvar b = 0; b < 2; b++) begin : g_bank
    logic [WIDTH-1:0] sync [SYNC_STAGES];
    logic [WIDTH-1:0] s;
    logic [WIDTH-1:0] cand, cand_nxt;
    logic [WIDTH-1:0] out_q, out_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             upd;

    // Sync flops idle at the pin level of logical 0 so reset release causes no spurious change
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        for (int i = 0; i < SYNC_STAGES; i++) sync[i] <= RAW_IDLE;
      end else begin
        sync[0] <= raw[b];
        for (int i = 1; i < SYNC_STAGES; i++) sync[i] <= sync[i-1];
      end
    end

    assign s = ACTIVE_LOW ? ~sync[SYNC_STAGES-1] : sync[SYNC_STAGES-1];

    always_comb begin
      cand_nxt = cand;
      cnt_nxt  = cnt;
      out_nxt  = out_q;
      upd      = 1'b0;
      if (s == out_q) begin
        cnt_nxt  = '0;
        cand_nxt = out_q;
      end else if (s != cand) begin
        cand_nxt = s;
        cnt_nxt  = CNT_W'(1);
      end else if (cnt == CNT_LAST) begin
        out_nxt = cand;
        cnt_nxt = '0;
        upd     = 1'b1;
      end else begin
        cnt_nxt = cnt + 1'b1;
      end
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        cand  <= '0;
        cnt   <= '0;
        out_q <= '0;
      end else begin
        cand  <= cand_nxt;
        cnt   <= cnt_nxt;
        out_q <= out_nxt;
      end
    end

    assign deb[b]      = out_q;
    assign bank_upd[b] = upd;
  end

  // Registered alongside the output update, so the pulse coincides with the new value
  always_ff @(posedge clk or posedge reset) begin
    if (reset) sw_changed <= 1'b0;
    else       sw_changed <= bank_upd[0] | bank_upd[1];
  end

  assign onboard_sw = deb[0];
  assign bboard_sw  = deb[1];

endmodule

// File: tb/tb_sw_debounce.sv
// Self-checking bench for sw_debounce: a run-length behavioural model checked every cycle,
// plus directed scenarios with hand-computed edge-exact expectations.
`timescale 1ns/1ps
module tb_sw_debounce;

  localparam int WIDTH         = 4;
  localparam int SYNC_STAGES   = 2;
  localparam int STABLE_CYCLES = 8;
  localparam bit ACTIVE_LOW    = 1'b1;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [WIDTH-1:0] onboard_sw_raw = 4'hF;
  logic [WIDTH-1:0] bboard_sw_raw  = 4'hF;
  logic [WIDTH-1:0] onboard_sw;
  logic [WIDTH-1:0] bboard_sw;
  logic             sw_changed;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  sw_debounce #(
    .WIDTH(WIDTH), .SYNC_STAGES(SYNC_STAGES),
    .STABLE_CYCLES(STABLE_CYCLES), .ACTIVE_LOW(ACTIVE_LOW)
  ) dut (
    .clk(clk), .reset(reset),
    .onboard_sw_raw(onboard_sw_raw), .bboard_sw_raw(bboard_sw_raw),
    .onboard_sw(onboard_sw), .bboard_sw(bboard_sw), .sw_changed(sw_changed)
  );

  task automatic checkOutput(input string name, input logic [WIDTH-1:0] act,
                             input logic [WIDTH-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a value is accepted once the synchronised logical value has differed from the
  // current output and stayed identical for STABLE_CYCLES consecutive clocks.
  logic [WIDTH-1:0] m_pipe [2][SYNC_STAGES];
  logic [WIDTH-1:0] m_out [2];
  logic [WIDTH-1:0] m_val [2];
  int               m_run [2];
  logic             m_chg;
  logic [WIDTH-1:0] m_raw [2];
  logic [WIDTH-1:0] m_seen;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int b = 0; b < 2; b++) begin
        for (int k = 0; k < SYNC_STAGES; k++) m_pipe[b][k] = '0;
        m_out[b] = '0;
        m_val[b] = '0;
        m_run[b] = 0;
      end
      m_chg = 1'b0;
    end else begin
      m_chg    = 1'b0;
      m_raw[0] = ACTIVE_LOW ? ~onboard_sw_raw : onboard_sw_raw;
      m_raw[1] = ACTIVE_LOW ? ~bboard_sw_raw  : bboard_sw_raw;
      for (int b = 0; b < 2; b++) begin
        m_seen = m_pipe[b][SYNC_STAGES-1];
        for (int k = SYNC_STAGES - 1; k > 0; k--) m_pipe[b][k] = m_pipe[b][k-1];
        m_pipe[b][0] = m_raw[b];
        if (m_seen == m_out[b]) begin
          m_run[b] = 0;
        end else begin
          if (m_run[b] != 0 && m_seen == m_val[b]) m_run[b] = m_run[b] + 1;
          else begin
            m_val[b] = m_seen;
            m_run[b] = 1;
          end
          if (m_run[b] == STABLE_CYCLES) begin
            m_out[b] = m_seen;
            m_run[b] = 0;
            m_chg    = 1'b1;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    checkOutput("model onboard_sw", onboard_sw, m_out[0]);
    checkOutput("model bboard_sw", bboard_sw, m_out[1]);
    checkOutput("model sw_changed", {3'b000, sw_changed}, {3'b000, m_chg});
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [WIDTH-1:0] ob, input logic [WIDTH-1:0] bb);
    onboard_sw_raw = ob;
    bboard_sw_raw  = bb;
  endtask

  task automatic doReset();
    reset = 1'b1;
    applyStimulus(4'hF, 4'hF);
    tick(3);
    checkOutput("reset onboard_sw", onboard_sw, 4'h0);
    checkOutput("reset sw_changed", {3'b000, sw_changed}, 4'h0);
    reset = 1'b0;
    tick(2);
  endtask

  initial begin
    // Reset with all switches off, then hold idle
    tick(3);
    checkOutput("t1 onboard_sw in reset", onboard_sw, 4'h0);
    checkOutput("t1 bboard_sw in reset", bboard_sw, 4'h0);
    checkOutput("t1 sw_changed in reset", {3'b000, sw_changed}, 4'h0);
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      checkOutput("t1 onboard_sw idle", onboard_sw, 4'h0);
      checkOutput("t1 sw_changed idle", {3'b000, sw_changed}, 4'h0);
    end

    // Clean change lands exactly 10 edges later with a one-cycle pulse
    applyStimulus(4'hA, 4'hF);
    tick(9);
    checkOutput("t2 onboard_sw edge9", onboard_sw, 4'h0);
    checkOutput("t2 sw_changed edge9", {3'b000, sw_changed}, 4'h0);
    tick(1);
    checkOutput("t2 onboard_sw edge10", onboard_sw, 4'h5);
    checkOutput("t2 sw_changed edge10", {3'b000, sw_changed}, 4'h1);
    checkOutput("t2 bboard_sw edge10", bboard_sw, 4'h0);
    tick(1);
    checkOutput("t2 onboard_sw edge11", onboard_sw, 4'h5);
    checkOutput("t2 sw_changed edge11", {3'b000, sw_changed}, 4'h0);

    // Bounce every 3 cycles, then settle
    doReset();
    for (int i = 0; i < 10; i++) begin
      applyStimulus((i % 2 == 0) ? 4'hE : 4'hF, 4'hF);
      for (int j = 0; j < 3; j++) begin
        tick(1);
        checkOutput("t3 onboard_sw bouncing", onboard_sw, 4'h0);
      end
    end
    applyStimulus(4'hE, 4'hF);
    tick(9);
    checkOutput("t3 onboard_sw edge9", onboard_sw, 4'h0);
    tick(1);
    checkOutput("t3 onboard_sw edge10", onboard_sw, 4'h1);
    checkOutput("t3 sw_changed edge10", {3'b000, sw_changed}, 4'h1);

    // Seven-cycle glitch must be rejected
    doReset();
    applyStimulus(4'h0, 4'hF);
    tick(7);
    applyStimulus(4'hF, 4'hF);
    for (int i = 0; i < 20; i++) begin
      tick(1);
      checkOutput("t4 onboard_sw glitch", onboard_sw, 4'h0);
      checkOutput("t4 sw_changed glitch", {3'b000, sw_changed}, 4'h0);
    end

    // Both banks together produce one pulse
    doReset();
    applyStimulus(4'h3, 4'h3);
    tick(9);
    checkOutput("t5 onboard_sw edge9", onboard_sw, 4'h0);
    checkOutput("t5 sw_changed edge9", {3'b000, sw_changed}, 4'h0);
    tick(1);
    checkOutput("t5 onboard_sw edge10", onboard_sw, 4'hC);
    checkOutput("t5 bboard_sw edge10", bboard_sw, 4'hC);
    checkOutput("t5 sw_changed edge10", {3'b000, sw_changed}, 4'h1);
    tick(1);
    checkOutput("t5 sw_changed edge11", {3'b000, sw_changed}, 4'h0);

    // Reset in the middle of a count forces a full recount
    doReset();
    applyStimulus(4'h3, 4'hF);
    tick(6);
    reset = 1'b1;
    #1;
    checkOutput("t6 onboard_sw async reset", onboard_sw, 4'h0);
    tick(2);
    checkOutput("t6 onboard_sw held reset", onboard_sw, 4'h0);
    reset = 1'b0;
    tick(9);
    checkOutput("t6 onboard_sw release+9", onboard_sw, 4'h0);
    checkOutput("t6 sw_changed release+9", {3'b000, sw_changed}, 4'h0);
    tick(1);
    checkOutput("t6 onboard_sw release+10", onboard_sw, 4'hC);
    checkOutput("t6 sw_changed release+10", {3'b000, sw_changed}, 4'h1);
    tick(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
